iic_target_resp: RTL and testbench

//  I2C target (responder) for the iic_drive master protocol: START, dev+W, reg_hi, reg_lo, then data (write)
//  or Sr, dev+R, data (read), STOP. Oversamples SCL/SDA on clk_i and bridges transfers to a 16-bit-address,
//  8-bit-data register port. Sits in front of the local register bank or model of a target device.

---
 rtl/iic_target_resp.sv | 215 +++++++++++++++++++++
 tb/tb_iic_target_resp.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_target_resp.sv
// I2C target responder bridging dev/reg_hi/reg_lo/data transfers to a 16-bit-address register port.
// Optional build macro IIC_TARGET_AUTOINC_EN enables multi-byte bursts with address auto-increment.
module iic_target_resp #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        busy,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata
);

    localparam int unsigned HOLD_LD = (HOLD_CYC == 0) ? 1 : HOLD_CYC;
    localparam int unsigned HW      = $clog2(HOLD_LD + 1);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, REG_H, ACK_H, REG_L, ACK_L,
        WR_DAT, ACK_WR, RD_DAT, M_ACK, WAIT_STOP
    } state_t;

    state_t        state_q;
    logic [1:0]    sclSync_q, sdaSync_q;
    logic          sclDly_q, sdaDly_q;
    logic [3:0]    bitCnt_q;
    logic [7:0]    rxShift_q, txShift_q, addrHi_q;
    logic [HW-1:0] holdCnt_q;
    logic          addrValid_q, isRead_q, mAck_q, rdWait_q;
    logic          sdaOe_q, busy_q, regWrEn_q, regRdEn_q;
    logic [15:0]   regAddr_q;
    logic [7:0]    regWdata_q;

    logic       sclNow, sdaNow, sclRise, sclFall, startDet, stopDet, oe_d;
    logic [7:0] rxByte;

    assign sclNow   = sclSync_q[1];
    assign sdaNow   = sdaSync_q[1];
    assign sclRise  = sclNow & ~sclDly_q;
    assign sclFall  = ~sclNow & sclDly_q;
    assign startDet = sclNow & sclDly_q & sdaDly_q & ~sdaNow;
    assign stopDet  = sclNow & sclDly_q & ~sdaDly_q & sdaNow;
    assign rxByte   = {rxShift_q[6:0], sdaNow};

    // Level SDA should take in the current low phase; applied only once the hold time has elapsed.
    always_comb begin
        oe_d = 1'b0;
        case (state_q)
            ACK_DEV, ACK_H, ACK_L, ACK_WR: oe_d = 1'b1;
            RD_DAT:                        oe_d = ~txShift_q[7];
            default:                       oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q     <= IDLE;
            sclSync_q   <= 2'b11;
            sdaSync_q   <= 2'b11;
            sclDly_q    <= 1'b1;
            sdaDly_q    <= 1'b1;
            bitCnt_q    <= '0;
            rxShift_q   <= '0;
            txShift_q   <= '0;
            addrHi_q    <= '0;
            holdCnt_q   <= '0;
            addrValid_q <= 1'b0;
            isRead_q    <= 1'b0;
            mAck_q      <= 1'b0;
            rdWait_q    <= 1'b0;
            sdaOe_q     <= 1'b0;
            busy_q      <= 1'b0;
            regWrEn_q   <= 1'b0;
            regRdEn_q   <= 1'b0;
            regAddr_q   <= '0;
            regWdata_q  <= '0;
        end else begin
            sclSync_q <= {sclSync_q[0], scl_i};
            sdaSync_q <= {sdaSync_q[0], sda_i};
            sclDly_q  <= sclSync_q[1];
            sdaDly_q  <= sdaSync_q[1];
            regWrEn_q <= 1'b0;
            regRdEn_q <= 1'b0;
            rdWait_q  <= regRdEn_q;
            if (rdWait_q) begin
                txShift_q <= reg_rdata;
            end

            if (startDet) begin
                state_q   <= DEV;
                bitCnt_q  <= '0;
                sdaOe_q   <= 1'b0;
                holdCnt_q <= '0;
                busy_q    <= 1'b0;
            end else if (stopDet) begin
                state_q     <= IDLE;
                bitCnt_q    <= '0;
                sdaOe_q     <= 1'b0;
                holdCnt_q   <= '0;
                busy_q      <= 1'b0;
                addrValid_q <= 1'b0;
            end else begin
                if (holdCnt_q != '0) begin
                    holdCnt_q <= holdCnt_q - HW'(1);
                    if (holdCnt_q == HW'(1) && !sclNow) begin
                        sdaOe_q <= oe_d;
                    end
                end

                // Data bits are captured on SCL rise; byte-level decisions wait for the following fall.
                if (sclRise) begin
                    case (state_q)
                        DEV, REG_H, REG_L, WR_DAT: begin
                            rxShift_q <= rxByte;
                            bitCnt_q  <= bitCnt_q + 4'd1;
                            if (state_q == WR_DAT && bitCnt_q == 4'd7) begin
                                regWdata_q <= rxByte;
                                regWrEn_q  <= 1'b1;
                            end
                        end
                        RD_DAT: bitCnt_q <= bitCnt_q + 4'd1;
                        M_ACK: begin
                            mAck_q <= ~sdaNow;
`ifdef IIC_TARGET_AUTOINC_EN
                            if (!sdaNow) begin
                                regAddr_q <= regAddr_q + 16'd1;
                                regRdEn_q <= 1'b1;
                            end
`endif
                        end
                        default: ;
                    endcase
                end

                if (sclFall) begin
                    holdCnt_q <= HW'(HOLD_LD);
                    case (state_q)
                        DEV: if (bitCnt_q == 4'd8) begin
                            bitCnt_q <= '0;
                            if (rxShift_q[7:1] == DEV_ADDR && (!rxShift_q[0] || addrValid_q)) begin
                                state_q   <= ACK_DEV;
                                busy_q    <= 1'b1;
                                isRead_q  <= rxShift_q[0];
                                regRdEn_q <= rxShift_q[0];
                            end else begin
                                state_q <= WAIT_STOP;
                                busy_q  <= 1'b0;
                            end
                        end
                        REG_H: if (bitCnt_q == 4'd8) begin
                            bitCnt_q <= '0;
                            addrHi_q <= rxShift_q;
                            state_q  <= ACK_H;
                        end
                        REG_L: if (bitCnt_q == 4'd8) begin
                            bitCnt_q    <= '0;
                            regAddr_q   <= {addrHi_q, rxShift_q};
                            addrValid_q <= 1'b1;
                            state_q     <= ACK_L;
                        end
                        WR_DAT: if (bitCnt_q == 4'd8) begin
                            bitCnt_q <= '0;
                            state_q  <= ACK_WR;
                        end
                        ACK_DEV: state_q <= isRead_q ? RD_DAT : REG_H;
                        ACK_H:   state_q <= REG_L;
                        ACK_L:   state_q <= WR_DAT;
                        ACK_WR: begin
`ifdef IIC_TARGET_AUTOINC_EN
                            regAddr_q <= regAddr_q + 16'd1;
                            state_q   <= WR_DAT;
`else
                            state_q   <= WAIT_STOP;
`endif
                        end
                        RD_DAT: begin
                            if (bitCnt_q == 4'd8) begin
                                bitCnt_q <= '0;
                                state_q  <= M_ACK;
                            end else begin
                                txShift_q <= {txShift_q[6:0], 1'b1};
                            end
                        end
                        M_ACK: begin
                            if (mAck_q) begin
`ifdef IIC_TARGET_AUTOINC_EN
                                state_q <= RD_DAT;
`else
                                state_q <= WAIT_STOP;
`endif
                            end else begin
                                state_q <= WAIT_STOP;
                                busy_q  <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign sda_oe    = sdaOe_q;
    assign busy      = busy_q;
    assign reg_wr_en = regWrEn_q;
    assign reg_rd_en = regRdEn_q;
    assign reg_addr  = regAddr_q;
    assign reg_wdata = regWdata_q;

endmodule

// File: tb/tb_iic_target_resp.sv
// Self-checking bench for iic_target_resp: bit-banged I2C master on a wired-AND SDA plus a strobe scoreboard.
`timescale 1ns/1ps
module tb_iic_target_resp;

    localparam int Q = 6;

    typedef struct {
        bit          isWrite;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        masterScl = 1'b1;
    logic        masterSda = 1'b1;
    logic [7:0]  rdataReg = 8'h00;
    logic [7:0]  rdValue = 8'h3C;
    logic        sda_oe, busy, reg_wr_en, reg_rd_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    wire         sdaBus = masterSda & ~sda_oe;

    int   nCompared = 0;
    int   nMismatched = 0;
    int   wrCount = 0;
    int   rdCount = 0;
    int   oeHighCnt = 0;
    int   busyHighCnt = 0;
    exp_t expQ[$];

    iic_target_resp dut (
        .clk_i(clk), .rst(rst), .scl_i(masterScl), .sda_i(sdaBus),
        .sda_oe(sda_oe), .busy(busy), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdataReg)
    );

    always #5 clk = ~clk;

    // Register bank model: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (reg_rd_en) rdataReg <= rdValue;
        if (sda_oe) oeHighCnt <= oeHighCnt + 1;
        if (busy) busyHighCnt <= busyHighCnt + 1;
    end

    // Every strobe is matched against the oldest expected transfer.
    always @(negedge clk) begin
        if (reg_wr_en || reg_rd_en) begin
            exp_t e;
            nCompared++;
            if (reg_wr_en) wrCount++;
            if (reg_rd_en) rdCount++;
            if (reg_wr_en && reg_rd_en) begin
                nMismatched++;
                $display("[TB] FAIL strobe_overlap: wr=%b rd=%b required not both", reg_wr_en, reg_rd_en);
            end else if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL unexpected_strobe: wr=%b addr=%h data=%h required none", reg_wr_en, reg_addr, reg_wdata);
            end else begin
                e = expQ.pop_front();
                if (e.isWrite !== reg_wr_en || e.addr !== reg_addr || (e.isWrite && e.data !== reg_wdata)) begin
                    nMismatched++;
                    $display("[TB] FAIL strobe: got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                             reg_wr_en, reg_addr, reg_wdata, e.isWrite, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2cStart();
        masterSda = 1'b1; waitQ();
        masterScl = 1'b1; waitQ();
        masterSda = 1'b0; waitQ();
        masterScl = 1'b0; waitQ();
    endtask

    task automatic i2cStop();
        masterSda = 1'b0; waitQ();
        masterScl = 1'b1; waitQ();
        masterSda = 1'b1; waitQ();
    endtask

    task automatic sendBit(input logic b, output logic s);
        masterSda = b; waitQ();
        masterScl = 1'b1; waitQ();
        s = sdaBus; waitQ();
        masterScl = 1'b0; waitQ();
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) sendBit(b[i], s);
        sendBit(1'b1, s);
        ack = ~s;
    endtask

    task automatic readByte(input logic giveAck, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sendBit(1'b1, s);
            d[i] = s;
        end
        sendBit(~giveAck, s);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nCompared++;
        if ({sda_oe, busy, reg_wr_en, reg_rd_en} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_ctrl: got oe/busy/wr/rd=%b required 0000", {sda_oe, busy, reg_wr_en, reg_rd_en});
        end
        nCompared++;
        if (reg_addr !== 16'h0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_addr: got %h required 0000", reg_addr);
        end
        nCompared++;
        if (reg_wdata !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL reset_wdata: got %h required 00", reg_wdata);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        nCompared++;
        if ({sda_oe, busy} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL idle_after_reset: got oe/busy=%b required 00", {sda_oe, busy});
        end
    endtask

    task automatic test_write();
        logic [3:0] acks;
        logic busyMid;
        int wrBase = wrCount;
        i2cStart();
        writeByte(8'hA0, acks[3]);
        busyMid = busy;
        writeByte(8'h12, acks[2]);
        writeByte(8'h34, acks[1]);
        expQ.push_back('{1'b1, 16'h1234, 8'hA5});
        writeByte(8'hA5, acks[0]);
        i2cStop();
        nCompared++;
        if (acks !== 4'b1111) begin
            nMismatched++;
            $display("[TB] FAIL write_acks: got %b required 1111", acks);
        end
        nCompared++;
        if (busyMid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL write_busy: got %b required 1", busyMid);
        end
        nCompared++;
        if (wrCount - wrBase !== 1 || expQ.size() !== 0) begin
            nMismatched++;
            $display("[TB] FAIL write_strobes: got %0d strobes, %0d pending required 1 and 0", wrCount - wrBase, expQ.size());
        end
        nCompared++;
        if ({reg_addr, reg_wdata} !== {16'h1234, 8'hA5}) begin
            nMismatched++;
            $display("[TB] FAIL write_regs: got %h/%h required 1234/a5", reg_addr, reg_wdata);
        end
    endtask

    task automatic test_read();
        logic [3:0] acks;
        logic [7:0] d;
        int rdBase = rdCount;
        rdValue = 8'h3C;
        i2cStart();
        writeByte(8'hA0, acks[3]);
        writeByte(8'h12, acks[2]);
        writeByte(8'h34, acks[1]);
        expQ.push_back('{1'b0, 16'h1234, 8'h00});
        i2cStart();
        writeByte(8'hA1, acks[0]);
        readByte(1'b0, d);
        i2cStop();
        nCompared++;
        if (acks !== 4'b1111) begin
            nMismatched++;
            $display("[TB] FAIL read_acks: got %b required 1111", acks);
        end
        nCompared++;
        if (d !== 8'h3C) begin
            nMismatched++;
            $display("[TB] FAIL read_byte: got %h required 3c", d);
        end
        nCompared++;
        if (rdCount - rdBase !== 1 || expQ.size() !== 0 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL read_end: got %0d strobes, %0d pending, busy=%b required 1, 0, 0",
                     rdCount - rdBase, expQ.size(), busy);
        end
    endtask

    task automatic test_mismatch();
        logic [2:0] acks;
        int oeBase = oeHighCnt;
        int busyBase = busyHighCnt;
        int strBase = wrCount + rdCount;
        i2cStart();
        writeByte(8'hA2, acks[2]);
        writeByte(8'h12, acks[1]);
        writeByte(8'h34, acks[0]);
        i2cStop();
        nCompared++;
        if (acks !== 3'b000 || oeHighCnt - oeBase !== 0) begin
            nMismatched++;
            $display("[TB] FAIL mismatch_oe: got acks=%b oe cycles=%0d required 000 and 0", acks, oeHighCnt - oeBase);
        end
        nCompared++;
        if (busyHighCnt - busyBase !== 0 || wrCount + rdCount - strBase !== 0) begin
            nMismatched++;
            $display("[TB] FAIL mismatch_quiet: got busy cycles=%0d strobes=%0d required 0 and 0",
                     busyHighCnt - busyBase, wrCount + rdCount - strBase);
        end
    endtask

    task automatic test_abort();
        logic a0, a1, a2, s;
        int strBase = wrCount + rdCount;
        i2cStart();
        writeByte(8'hA0, a0);
        writeByte(8'h12, a1);
        for (int i = 7; i >= 4; i--) sendBit(1'b0, s);
        i2cStop();
        i2cStart();
        writeByte(8'hA1, a2);
        i2cStop();
        nCompared++;
        if ({a0, a1, a2} !== 3'b110) begin
            nMismatched++;
            $display("[TB] FAIL abort_acks: got %b required 110", {a0, a1, a2});
        end
        nCompared++;
        if (wrCount + rdCount - strBase !== 0 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL abort_quiet: got strobes=%0d busy=%b required 0 and 0", wrCount + rdCount - strBase, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic a0, s, oeBefore, oeAfter, busyAfter;
        logic [3:0] acks;
        i2cStart();
        writeByte(8'hA0, a0);
        for (int i = 7; i >= 0; i--) sendBit(1'b0, s);
        masterSda = 1'b1; waitQ();
        masterScl = 1'b1; waitQ();
        oeBefore = sda_oe;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        oeAfter = sda_oe;
        busyAfter = busy;
        rst = 1'b0;
        waitQ();
        masterScl = 1'b0; waitQ();
        i2cStop();
        nCompared++;
        if ({a0, oeBefore, oeAfter, busyAfter} !== 4'b1100) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid: got ack/oe_before/oe_after/busy=%b required 1100",
                     {a0, oeBefore, oeAfter, busyAfter});
        end
        i2cStart();
        writeByte(8'hA0, acks[3]);
        writeByte(8'hAB, acks[2]);
        writeByte(8'hCD, acks[1]);
        expQ.push_back('{1'b1, 16'hABCD, 8'h5A});
        writeByte(8'h5A, acks[0]);
        i2cStop();
        nCompared++;
        if (acks !== 4'b1111 || expQ.size() !== 0) begin
            nMismatched++;
            $display("[TB] FAIL reset_recover: got acks=%b pending=%0d required 1111 and 0", acks, expQ.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] acks;
        logic [4:0] want;
        int wrBase = wrCount;
        i2cStart();
        writeByte(8'hA0, acks[4]);
        writeByte(8'hFF, acks[3]);
        writeByte(8'hFF, acks[2]);
        expQ.push_back('{1'b1, 16'hFFFF, 8'h11});
        writeByte(8'h11, acks[1]);
`ifdef IIC_TARGET_AUTOINC_EN
        expQ.push_back('{1'b1, 16'h0000, 8'h22});
        want = 5'b11111;
`else
        want = 5'b11110;
`endif
        writeByte(8'h22, acks[0]);
        i2cStop();
        nCompared++;
        if (acks !== want) begin
            nMismatched++;
            $display("[TB] FAIL burst_acks: got %b required %b", acks, want);
        end
        nCompared++;
        if (expQ.size() !== 0 || wrCount - wrBase !== (want[0] ? 2 : 1)) begin
            nMismatched++;
            $display("[TB] FAIL burst_strobes: got %0d strobes, %0d pending required %0d and 0",
                     wrCount - wrBase, expQ.size(), want[0] ? 2 : 1);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
